plot_sink: RTL and testbench

Receiving end of the pixel-plot interface: accepts one `plot` strobe per clock with `x`/`y`/`colour`, as produced by the drawing datapaths, and turns it into a write on the 160x120 frame-buffer memory port. A 4-entry FIFO absorbs bursts while the frame-buffer port is stalled by scan-out arbitration. The block sits between the game datapaths and the frame-buffer RAM, taking the place of direct adapter wiring.

---
 rtl/plot_pkg.sv | 26 ++
 rtl/plot_sink_if.sv | 29 ++
 rtl/plot_sink_fifo.sv | 54 +++++
 rtl/plot_sink.sv | 138 +++++++++++++
 tb/tb_plot_sink.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/plot_pkg.sv
// Shared types and constants for the pixel-plot sink: screen geometry,
// frame-buffer widths, sink FSM states and the queued pixel record.
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_AW    = 15;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

  typedef struct packed {
    logic [FB_AW-1:0]    addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*160 + x built from shifts; operands are pre-widened so nothing wraps
  function automatic logic [FB_AW-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Plot strobe bus from the drawing datapaths plus the frame-buffer write
// port; the sink uses the slave view, its environment the master view.
interface plot_sink_if;

  logic                          plot;
  logic [7:0]                    x;
  logic [6:0]                    y;
  logic [plot_pkg::COLOUR_W-1:0] colour;
  logic                          ready;
  logic                          overflow;
  logic                          range_err;
  logic                          clear;
  logic                          clear_done;
  logic                          fb_we;
  logic [plot_pkg::FB_AW-1:0]    fb_addr;
  logic [plot_pkg::COLOUR_W-1:0] fb_data;
  logic                          fb_busy;

  modport slave (
    input  plot, x, y, colour, clear, fb_busy,
    output ready, overflow, range_err, clear_done, fb_we, fb_addr, fb_data
  );

  modport master (
    output plot, x, y, colour, clear, fb_busy,
    input  ready, overflow, range_err, clear_done, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/plot_sink_fifo.sv
// Small synchronous FIFO of pixel records that soaks up plot bursts while
// the frame-buffer port is stalled. Head is visible on dout when non-empty.
module plot_fifo
  import plot_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  pixel_t        din,
  input  logic          pop,
  output pixel_t        dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plot_sink.sv
// Receiving end of the pixel-plot bus: queues in-range plots and writes them
// to the 160x120 frame buffer. Define PLOT_SINK_CLEAR_EN for full-screen clear.
module plot_sink
  import plot_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int DEPTH  = 4
) (
  input logic        clk,
  input logic        resetn,
  plot_sink_if.slave bus
);

  localparam int          CNT_W = $clog2(DEPTH) + 1;
  localparam logic [7:0] W_LIM  = 8'(WIDTH);
  localparam logic [6:0] H_LIM  = 7'(HEIGHT);

  state_t             state;
  state_t             next_state;
  pixel_t             head;
  pixel_t             push_pix;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               in_range;
  logic               push;
  logic               pop;
  logic               overflow_q;
  logic               range_err_q;
  logic               fb_we;
  logic [FB_AW-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;

  assign in_range        = (bus.x < W_LIM) && (bus.y < H_LIM);
  assign push            = bus.plot && !full && in_range;
  assign pop             = (state == DRAIN) && !bus.fb_busy;
  assign push_pix.addr   = pixel_addr(bus.x, bus.y);
  assign push_pix.colour = bus.colour;

  plot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .din   (push_pix),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef PLOT_SINK_CLEAR_EN
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(WIDTH * HEIGHT - 1);

  logic             clear_pending;
  logic             clear_req;
  logic             clear_last;
  logic             clear_done_q;
  logic [FB_AW-1:0] clear_addr;

  assign clear_req  = clear_pending || bus.clear;
  assign clear_last = (state == CLEAR) && !bus.fb_busy && (clear_addr == LAST_ADDR);

  // A clear request waits until the queue has drained; requests seen mid-sweep are dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clear_pending <= 1'b0;
      clear_addr    <= '0;
      clear_done_q  <= 1'b0;
    end else begin
      clear_done_q <= clear_last;
      if (next_state == CLEAR || state == CLEAR) clear_pending <= 1'b0;
      else if (bus.clear)                        clear_pending <= 1'b1;
      if (state != CLEAR)    clear_addr <= '0;
      else if (!bus.fb_busy) clear_addr <= clear_last ? '0 : clear_addr + 1'b1;
    end
  end

  assign bus.clear_done = clear_done_q;
`else
  logic unused_clear;
  assign unused_clear   = bus.clear;
  assign bus.clear_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state       <= next_state;
      overflow_q  <= overflow_q || (bus.plot && full && in_range);
      range_err_q <= bus.plot && !in_range;
    end
  end

  // Outputs are zero outside an active write so the port idles at a known address
  always_comb begin
    next_state = state;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    case (state)
      IDLE: begin
        if (!empty || push) next_state = DRAIN;
`ifdef PLOT_SINK_CLEAR_EN
        else if (clear_req) next_state = CLEAR;
`endif
      end
      DRAIN: begin
        fb_we   = 1'b1;
        fb_addr = head.addr;
        fb_data = head.colour;
        if (pop && count == CNT_W'(1) && !push) next_state = IDLE;
      end
      CLEAR: begin
`ifdef PLOT_SINK_CLEAR_EN
        fb_we   = 1'b1;
        fb_addr = clear_addr;
        if (clear_last) next_state = (empty && !push) ? IDLE : DRAIN;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.ready     = !full;
  assign bus.overflow  = overflow_q;
  assign bus.range_err = range_err_q;
  assign bus.fb_we     = fb_we;
  assign bus.fb_addr   = fb_addr;
  assign bus.fb_data   = fb_data;

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink with a write scoreboard; build with
// PLOT_SINK_CLEAR_EN defined to also exercise the full-screen clear.
module tb_plot_sink;
  import plot_pkg::*;

  logic clk;
  logic resetn;
  int   compared;
  int   mismatched;
  int   writes_seen;
  pixel_t sb[$];

  plot_sink_if bus ();

  plot_sink #(.WIDTH(160), .HEIGHT(120), .DEPTH(4)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic pixel_t exp_pix(input int px, input int py, input int pc);
    pixel_t p;
    p.addr   = 15'(py * 160 + px);
    p.colour = 3'(pc);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int px, input int py, input int pc);
    bus.plot   = 1'b1;
    bus.x      = 8'(px);
    bus.y      = 7'(py);
    bus.colour = 3'(pc);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) tick();
    check_output("drain_done", 32'(sb.size()), 0);
  endtask

  // Every completed write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resetn && bus.fb_we && !bus.fb_busy) begin
      writes_seen++;
      if (sb.size() == 0) begin
        check_output("unexpected_write", 32'(bus.fb_we), 0);
      end else begin
        pixel_t e;
        e = sb.pop_front();
        check_output("write", 32'({bus.fb_addr, bus.fb_data}), 32'(e));
      end
    end
  end

  initial begin
    compared    = 0;
    mismatched  = 0;
    writes_seen = 0;
    resetn      = 1'b0;
    bus.plot    = 1'b0;
    bus.x       = '0;
    bus.y       = '0;
    bus.colour  = '0;
    bus.clear   = 1'b0;
    bus.fb_busy = 1'b0;

    #12;
    check_output("rst_ready",      32'(bus.ready), 1);
    check_output("rst_overflow",   32'(bus.overflow), 0);
    check_output("rst_range_err",  32'(bus.range_err), 0);
    check_output("rst_clear_done", 32'(bus.clear_done), 0);
    check_output("rst_fb_we",      32'(bus.fb_we), 0);
    check_output("rst_fb_addr",    32'(bus.fb_addr), 0);
    check_output("rst_fb_data",    32'(bus.fb_data), 0);
    resetn = 1'b1;
    tick();

    // Single plot: write appears the cycle after acceptance
    apply_stimulus(2, 5, 7);
    sb.push_back(exp_pix(2, 5, 7));
    tick();
    bus.plot = 1'b0;
    check_output("single_we",   32'(bus.fb_we), 1);
    check_output("single_addr", 32'(bus.fb_addr), 802);
    check_output("single_data", 32'(bus.fb_data), 7);
    tick();
    check_output("single_idle", 32'(bus.fb_we), 0);

    // Burst of five while stalled: four queued, fifth overflows
    bus.fb_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(10 + i, i, i + 1);
      sb.push_back(exp_pix(10 + i, i, i + 1));
      tick();
    end
    check_output("full_ready",     32'(bus.ready), 0);
    check_output("full_overflow0", 32'(bus.overflow), 0);
    apply_stimulus(14, 4, 5);
    tick();
    bus.plot = 1'b0;
    check_output("overflow_set", 32'(bus.overflow), 1);
    for (int i = 0; i < 3; i++) begin
      check_output("stall_we",   32'(bus.fb_we), 1);
      check_output("stall_addr", 32'(bus.fb_addr), 10);
      tick();
    end
    bus.fb_busy = 1'b0;
    wait_drain(10);
    tick();
    check_output("burst_idle",   32'(bus.fb_we), 0);
    check_output("burst_ready",  32'(bus.ready), 1);
    check_output("sticky_ovf",   32'(bus.overflow), 1);

    // Out-of-range coordinates on each axis
    apply_stimulus(160, 0, 1);
    tick();
    bus.plot = 1'b0;
    check_output("range_x_pulse", 32'(bus.range_err), 1);
    check_output("range_x_no_we", 32'(bus.fb_we), 0);
    tick();
    check_output("range_x_clear", 32'(bus.range_err), 0);
    apply_stimulus(0, 120, 2);
    tick();
    bus.plot = 1'b0;
    check_output("range_y_pulse", 32'(bus.range_err), 1);
    check_output("range_y_no_we", 32'(bus.fb_we), 0);
    tick();
    check_output("range_y_clear", 32'(bus.range_err), 0);

    // Streaming at full rate, boundary coordinates included
    for (int i = 0; i < 10; i++) begin
      apply_stimulus((i * 17) % 160, (i == 9) ? 119 : i * 11, i);
      sb.push_back(exp_pix((i * 17) % 160, (i == 9) ? 119 : i * 11, i));
      tick();
      check_output("stream_ready", 32'(bus.ready), 1);
    end
    bus.plot = 1'b0;
    check_output("stream_last_we",   32'(bus.fb_we), 1);
    check_output("stream_last_addr", 32'(bus.fb_addr), 119 * 160 + 153);
    tick();
    check_output("stream_drained", 32'(sb.size()), 0);
    check_output("stream_idle",    32'(bus.fb_we), 0);

    // Asynchronous reset with entries queued behind a stall
    bus.fb_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(50 + i, 60, 3);
      tick();
    end
    bus.plot = 1'b0;
    check_output("prereset_we", 32'(bus.fb_we), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("async_rst_we", 32'(bus.fb_we), 0);
    sb.delete();
    bus.fb_busy = 1'b0;
    #10;
    resetn = 1'b1;
    repeat (8) tick();
    check_output("postrst_we",       32'(bus.fb_we), 0);
    check_output("postrst_ready",    32'(bus.ready), 1);
    check_output("postrst_overflow", 32'(bus.overflow), 0);

`ifdef PLOT_SINK_CLEAR_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int a = 0; a < 19200; a++) sb.push_back(exp_pix(a % 160, a / 160, 0));
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check_output("clear_start_we",   32'(bus.fb_we), 1);
      check_output("clear_start_addr", 32'(bus.fb_addr), 0);
      repeat (100) tick();
      apply_stimulus(1, 1, 5);
      sb.push_back(exp_pix(1, 1, 5));
      tick();
      bus.plot    = 1'b0;
      bus.fb_busy = 1'b1;
      repeat (5) tick();
      bus.fb_busy = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
        tick();
        if (bus.clear_done) seen = 1'b1;
      end
      check_output("clear_done_seen", 32'(seen), 1);
      check_output("post_clear_addr", 32'(bus.fb_addr), 161);
      tick();
      check_output("clear_done_pulse", 32'(bus.clear_done), 0);
      wait_drain(10);
    end
`else
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (3) begin
      check_output("clear_ignored_we",   32'(bus.fb_we), 0);
      check_output("clear_ignored_done", 32'(bus.clear_done), 0);
      tick();
    end
`endif

    tick();
    check_output("final_idle", 32'(bus.fb_we), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
